// File: rtl/udma_pattern_gen.sv
// Multi-channel test-pattern source for the uDMA RX linear channels.
// Each channel runs its own IDLE/RUN/GAP/DONE machine behind a valid/ready handshake.
module udma_pattern_gen #(
    parameter int          N_CH       = 2,
    parameter int          DATA_WIDTH = 32,
    parameter int          CNT_WIDTH  = 16,
    parameter int          GAP_WIDTH  = 4,
    parameter logic [31:0] LFSR_POLY  = 32'h8020_0003
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_CH-1:0]              cfg_en_i,
    input  logic [2*N_CH-1:0]            cfg_mode_i,
    input  logic [N_CH*CNT_WIDTH-1:0]    cfg_len_i,
    input  logic [N_CH*DATA_WIDTH-1:0]   cfg_seed_i,
    input  logic [N_CH*GAP_WIDTH-1:0]    cfg_gap_i,
    output logic [N_CH*DATA_WIDTH-1:0]   udma_rx_lin_data_o,
    output logic [N_CH-1:0]              udma_rx_lin_valid_o,
    input  logic [N_CH-1:0]              udma_rx_lin_ready_i,
    output logic [N_CH-1:0]              busy_o,
    output logic [N_CH-1:0]              done_o,
    output logic [N_CH*CNT_WIDTH-1:0]    sent_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] MODE_INCR  = 2'b00;
    localparam logic [1:0] MODE_LFSR  = 2'b01;
    localparam logic [1:0] MODE_CONST = 2'b10;

    localparam logic [DATA_WIDTH-1:0] POLY = DATA_WIDTH'(LFSR_POLY);

    function automatic logic [DATA_WIDTH-1:0] next_word(input logic [1:0]            mode,
                                                        input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] res;
        res = d;
        case (mode)
            MODE_INCR:  res = d + DATA_WIDTH'(1);
            MODE_LFSR:  res = (d >> 1) ^ (d[0] ? POLY : '0);
            MODE_CONST: res = d;
            default:    res = {d[DATA_WIDTH-2:0], d[DATA_WIDTH-1]};
        endcase
        return res;
    endfunction

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic                  en;
        logic                  ready;
        logic [1:0]            mode_in;
        logic [CNT_WIDTH-1:0]  len_in;
        logic [DATA_WIDTH-1:0] seed_in;
        logic [GAP_WIDTH-1:0]  gap_in;

        state_e                state_q, state_d;
        logic [1:0]            mode_q, mode_d;
        logic [CNT_WIDTH-1:0]  len_q, len_d;
        logic [GAP_WIDTH-1:0]  gap_q, gap_d;
        logic [GAP_WIDTH-1:0]  gcnt_q, gcnt_d;
        logic [DATA_WIDTH-1:0] data_q, data_d;
        logic [CNT_WIDTH-1:0]  sent_q, sent_d;

        assign en      = cfg_en_i[c];
        assign ready   = udma_rx_lin_ready_i[c];
        assign mode_in = cfg_mode_i[2*c +: 2];
        assign len_in  = cfg_len_i[c*CNT_WIDTH +: CNT_WIDTH];
        assign seed_in = cfg_seed_i[c*DATA_WIDTH +: DATA_WIDTH];
        assign gap_in  = cfg_gap_i[c*GAP_WIDTH +: GAP_WIDTH];

        // LFSR and walking-one modes (mode bit 0 set) would lock up on an all-zero word.
        always_comb begin
            state_d = state_q;
            mode_d  = mode_q;
            len_d   = len_q;
            gap_d   = gap_q;
            gcnt_d  = gcnt_q;
            data_d  = data_q;
            sent_d  = sent_q;
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        mode_d  = mode_in;
                        len_d   = len_in;
                        gap_d   = gap_in;
                        sent_d  = '0;
                        data_d  = (mode_in[0] && seed_in == '0) ? DATA_WIDTH'(1) : seed_in;
                        state_d = (len_in == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ready) begin
                        sent_d = sent_q + CNT_WIDTH'(1);
                        data_d = next_word(mode_q, data_q);
                        if (!en) begin
                            state_d = ST_IDLE;
                        end else if (sent_q == len_q - CNT_WIDTH'(1)) begin
                            state_d = ST_DONE;
                        end else if (gap_q != '0) begin
                            state_d = ST_GAP;
                            gcnt_d  = gap_q;
                        end
                    end
                end
                ST_GAP: begin
                    if (!en) begin
                        state_d = ST_IDLE;
                    end else if (gcnt_q <= GAP_WIDTH'(1)) begin
                        state_d = ST_RUN;
                    end else begin
                        gcnt_d = gcnt_q - GAP_WIDTH'(1);
                    end
                end
                default: begin
                    if (!en) state_d = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= ST_IDLE;
                mode_q  <= '0;
                len_q   <= '0;
                gap_q   <= '0;
                gcnt_q  <= '0;
                data_q  <= '0;
                sent_q  <= '0;
            end else begin
                state_q <= state_d;
                mode_q  <= mode_d;
                len_q   <= len_d;
                gap_q   <= gap_d;
                gcnt_q  <= gcnt_d;
                data_q  <= data_d;
                sent_q  <= sent_d;
            end
        end

        assign udma_rx_lin_valid_o[c]                          = (state_q == ST_RUN);
        assign udma_rx_lin_data_o[c*DATA_WIDTH +: DATA_WIDTH]  = data_q;
        assign busy_o[c]                                       = (state_q == ST_RUN) || (state_q == ST_GAP);
        assign done_o[c]                                       = (state_q == ST_DONE);
        assign sent_cnt_o[c*CNT_WIDTH +: CNT_WIDTH]            = sent_q;
    end

endmodule
